// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: 5..DATA_W data bits, optional odd/even parity,
// one or two stop bits, runtime bit-period divisor. Frame settings latch on accept.
module uart_tx_param #(
  parameter int DATA_W = 9,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [3:0]        data_bits,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              stop2,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_line
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   baud_cnt, baud_nxt, div_q;
  logic [3:0]         bit_cnt, bit_nxt, nbits_q, nbits_clamped;
  logic [DATA_W-1:0]  shreg, shreg_nxt;
  logic               par_acc, par_nxt;
  logic               par_en_q, par_odd_q, stop2_q;
  logic               line_nxt, done_nxt;
  logic               accept, bit_end;

  assign tx_ready = (state == IDLE) && !rst;
  assign tx_busy  = (state != IDLE) && !rst;
  assign accept   = tx_valid && tx_ready;
  // >= rather than == so a counter can never run past the latched divisor
  assign bit_end  = (baud_cnt >= div_q);

  always_comb begin
    if (data_bits < 4'd5)               nbits_clamped = 4'd5;
    else if (data_bits > 4'(DATA_W))    nbits_clamped = 4'(DATA_W);
    else                                nbits_clamped = data_bits;
  end

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    baud_nxt  = bit_end ? '0 : baud_cnt + DIV_W'(1);
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    par_nxt   = par_acc;
    line_nxt  = tx_line;
    done_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        line_nxt = 1'b1;
        baud_nxt = '0;
        bit_nxt  = '0;
        if (accept) begin
          state_nxt = START;
          line_nxt  = 1'b0;
          shreg_nxt = tx_data;
          par_nxt   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          line_nxt  = shreg[0];
          bit_nxt   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          par_nxt   = par_acc ^ shreg[0];
          shreg_nxt = shreg >> 1;
          if (bit_cnt == nbits_q - 4'd1) begin
            bit_nxt = '0;
            if (par_en_q) begin
              state_nxt = PARITY;
              line_nxt  = par_acc ^ shreg[0] ^ par_odd_q;
            end else begin
              state_nxt = STOP;
              line_nxt  = 1'b1;
            end
          end else begin
            bit_nxt  = bit_cnt + 4'd1;
            line_nxt = shreg[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
          line_nxt  = 1'b1;
          bit_nxt   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!stop2_q || bit_cnt == 4'd1) begin
            state_nxt = IDLE;
            line_nxt  = 1'b1;
            done_nxt  = 1'b1;
            bit_nxt   = '0;
          end else begin
            bit_nxt = 4'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_acc   <= 1'b0;
      tx_line   <= 1'b1;
      tx_done   <= 1'b0;
      div_q     <= '0;
      nbits_q   <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      shreg    <= shreg_nxt;
      par_acc  <= par_nxt;
      tx_line  <= line_nxt;
      tx_done  <= done_nxt;
      if (accept) begin
        div_q     <= baud_div;
        nbits_q   <= nbits_clamped;
        par_en_q  <= parity_en;
        par_odd_q <= parity_odd;
        stop2_q   <= stop2;
      end
    end
  end

endmodule
